// File: rtl/rw_cmd_executor.sv
// rtl/rw_cmd_executor.sv - read/write command executor over a register-based memory
// Accepts one 192-bit command, executes it in one cycle, and holds a 64-bit response until taken.
module rw_cmd_executor #(
  parameter int          DEPTH    = 16,
  parameter logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [191:0]     cmd_data,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [63:0]      rsp_data,
  output logic [CNT_W-1:0] cnt_wr,
  output logic [CNT_W-1:0] cnt_rd,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RSP} state_e;

  state_e             state_q, state_d;
  logic [63:0]        op_q, addr_q, wdata_q;
  logic [63:0]        mem_q [DEPTH];
  logic [63:0]        rsp_data_q;
  logic [CNT_W-1:0]   cnt_wr_q, cnt_rd_q, cnt_err_q;

  logic               accept;
  logic               addr_ok, is_wr, is_rd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Full-width compare so out-of-range high address bits can never alias a valid word.
  assign addr_ok = (addr_q < 64'(DEPTH));
  assign is_wr   = (op_q == 64'd0) && addr_ok;
  assign is_rd   = (op_q == 64'd1) && addr_ok;
  assign accept  = (state_q == S_IDLE) && cmd_vld;

  always_comb begin
    state_d = state_q;
    cmd_rdy = 1'b0;
    rsp_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RSP;
      S_RSP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      cnt_wr_q   <= '0;
      cnt_rd_q   <= '0;
      cnt_err_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= cmd_data[63:0];
        addr_q  <= cmd_data[127:64];
        wdata_q <= cmd_data[191:128];
      end
      if (state_q == S_EXEC) begin
        if (is_wr) begin
          mem_q[addr_q[AW-1:0]] <= wdata_q;
          rsp_data_q            <= '0;
          cnt_wr_q              <= sat_inc(cnt_wr_q);
        end else if (is_rd) begin
          rsp_data_q <= mem_q[addr_q[AW-1:0]];
          cnt_rd_q   <= sat_inc(cnt_rd_q);
        end else begin
          rsp_data_q <= ERR_DATA;
          cnt_err_q  <= sat_inc(cnt_err_q);
        end
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign cnt_wr   = cnt_wr_q;
  assign cnt_rd   = cnt_rd_q;
  assign cnt_err  = cnt_err_q;

endmodule
